// File: rtl/board_controller.sv
// Tic-tac-toe game state: board register, turn alternation, per-turn timer
// and win/draw detection for the cursor-driven two-player game.
module board_controller #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pos,
    input  logic        place,
    input  logic        new_game,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        placed,
    output logic        rejected,
    output logic        timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TENABLE = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        PLAY,
        CHECK,
        OVER
    } state_t;

    state_t          state_q, state_d;
    logic [8:0][1:0] cells_q, cells_d;
    logic            turn_q, turn_d;
    logic [1:0]      winner_q, winner_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            place_q;
    logic            placed_q, placed_d;
    logic            rejected_q, rejected_d;
    logic            timeout_q, timeout_d;

    logic            confirm;
    logic            posOk;
    logic [3:0]      idx;
    logic [1:0]      mark;

    function automatic logic hasLine(input logic [8:0][1:0] c, input logic [1:0] m);
        hasLine = (c[0] == m && c[1] == m && c[2] == m) ||
                  (c[3] == m && c[4] == m && c[5] == m) ||
                  (c[6] == m && c[7] == m && c[8] == m) ||
                  (c[0] == m && c[3] == m && c[6] == m) ||
                  (c[1] == m && c[4] == m && c[7] == m) ||
                  (c[2] == m && c[5] == m && c[8] == m) ||
                  (c[0] == m && c[4] == m && c[8] == m) ||
                  (c[2] == m && c[4] == m && c[6] == m);
    endfunction

    function automatic logic isFull(input logic [8:0][1:0] c);
        isFull = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (c[i] == 2'b00) isFull = 1'b0;
        end
    endfunction

    assign confirm = place & ~place_q;
    assign posOk   = (pos <= 4'd8);
    assign idx     = posOk ? pos : 4'd0;
    assign mark    = turn_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d    = state_q;
        cells_d    = cells_q;
        turn_d     = turn_q;
        winner_d   = winner_q;
        timer_d    = timer_q;
        placed_d   = 1'b0;
        rejected_d = 1'b0;
        timeout_d  = 1'b0;

        if (new_game) begin
            state_d  = PLAY;
            cells_d  = '0;
            turn_d   = 1'b0;
            winner_d = 2'b00;
            timer_d  = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (confirm) begin
                        // A confirm of either kind leaves the timer untouched this cycle.
                        if (posOk && cells_q[idx] == 2'b00) begin
                            cells_d[idx] = mark;
                            placed_d     = 1'b1;
                            state_d      = CHECK;
                        end else begin
                            rejected_d = 1'b1;
                        end
                    end else if (TENABLE) begin
                        if (timer_q == TLAST) begin
                            timeout_d = 1'b1;
                            turn_d    = ~turn_q;
                            timer_d   = '0;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                CHECK: begin
                    // Only the mover can have completed a line, so a full board with a line is a win.
                    if (hasLine(cells_q, mark)) begin
                        winner_d = mark;
                        state_d  = OVER;
                    end else if (isFull(cells_q)) begin
                        winner_d = 2'b11;
                        state_d  = OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        timer_d = '0;
                        state_d = PLAY;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PLAY;
            cells_q    <= '0;
            turn_q     <= 1'b0;
            winner_q   <= 2'b00;
            timer_q    <= '0;
            place_q    <= 1'b0;
            placed_q   <= 1'b0;
            rejected_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cells_q    <= cells_d;
            turn_q     <= turn_d;
            winner_q   <= winner_d;
            timer_q    <= timer_d;
            place_q    <= place;
            placed_q   <= placed_d;
            rejected_q <= rejected_d;
            timeout_q  <= timeout_d;
        end
    end

    assign board     = cells_q;
    assign turn      = turn_q;
    assign winner    = winner_q;
    assign game_over = (state_q == OVER);
    assign placed    = placed_q;
    assign rejected  = rejected_q;
    assign timeout   = timeout_q;

endmodule
